vend_controller: RTL and testbench

Sequencing controller for the coin-operated vending datapath. It accumulates credit from the 2-bit coin input and arbitrates a two-product selection against that credit. It drives a request/acknowledge handshake to the product dispenser, then returns change as a train of 5-rupee pulses. It sits between the coin acceptor and the dispenser/change hopper.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_credit_acc.sv | 50 +++++
 rtl/vend_controller.sv | 148 ++++++++++++++
 tb/tb_vend_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared encodings and helpers for the vending controller.
// Imported by vend_credit_acc and vend_controller.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam logic [1:0] SEL_A = 2'b01;
  localparam logic [1:0] SEL_B = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE
  } state_t;

  // Coin value in 5-rupee units; none/invalid count as 0.
  function automatic logic [1:0] coin_value(input logic [1:0] c);
    logic [1:0] v;
    v = 2'd0;
    if (c == COIN_5)  v = 2'd1;
    if (c == COIN_10) v = 2'd2;
    return v;
  endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Credit register with add, price subtract and decrement-by-one.
// Flags coins that would push credit past the ceiling.
module vend_credit_acc
  import vend_pkg::*;
#(
  parameter int CW         = 4,
  parameter int MAX_CREDIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          add_en,
  input  logic [1:0]    add_val,
  input  logic          sub_en,
  input  logic [CW-1:0] sub_val,
  input  logic          dec_en,
  output logic [CW-1:0] credit,
  output logic          ovf
);

  logic [CW:0] sum;

  assign sum = {1'b0, credit} + {{(CW-1){1'b0}}, add_val};
  assign ovf = sum > (CW+1)'(MAX_CREDIT);

  // Credit update; subtract and decrement win over add.
  always_ff @(posedge clk) begin
    if (!rst) begin
      credit <= '0;
    end else if (sub_en) begin
      credit <= credit - sub_val;
    end else if (dec_en) begin
      credit <= credit - 1'b1;
    end else if (add_en && !ovf) begin
      credit <= sum[CW-1:0];
    end
  end

  a_ceiling: assert property (
    @(posedge clk) disable iff (!rst)
    credit <= CW'(MAX_CREDIT));

  a_no_sub_wrap: assert property (
    @(posedge clk) disable iff (!rst)
    sub_en |-> sub_val <= credit);

  a_no_dec_wrap: assert property (
    @(posedge clk) disable iff (!rst)
    dec_en |-> credit != '0);

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credit, selection, dispense handshake, change.
// Optional idle auto-refund when VEND_TIMEOUT_EN is defined.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_A     = 3,
  parameter int PRICE_B     = 4,
  parameter int MAX_CREDIT  = 8,
  parameter int CW          = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    coin,
  input  logic [1:0]    sel,
  input  logic          cancel,
  input  logic          disp_ack,
  output logic          disp_req,
  output logic          disp_item,
  output logic          change_pulse,
  output logic          coin_reject,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam logic [CW-1:0] PA = CW'(PRICE_A);
  localparam logic [CW-1:0] PB = CW'(PRICE_B);

  state_t        state, state_n;
  logic          item_n, pulse_n, rej_n;
  logic          add_en, sub_en, dec_en, ovf;
  logic          coin_act, want, can_buy, tmo;
  logic [CW-1:0] price;

  vend_credit_acc #(
    .CW        (CW),
    .MAX_CREDIT(MAX_CREDIT)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .add_en (add_en),
    .add_val(coin_value(coin)),
    .sub_en (sub_en),
    .sub_val(price),
    .dec_en (dec_en),
    .credit (credit),
    .ovf    (ovf)
  );

  assign coin_act = coin != COIN_NONE;
  assign want     = (sel == SEL_A) || (sel == SEL_B);
  assign price    = (sel == SEL_B) ? PB : PA;
  assign can_buy  = want && (credit >= price);

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] idle_cnt;
  logic          quiet;

  assign quiet = (state == COLLECT) && !coin_act
              && (sel == 2'b00) && !cancel;
  assign tmo   = quiet && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (!quiet || tmo) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      disp_item    <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      state        <= state_n;
      disp_item    <= item_n;
      change_pulse <= pulse_n;
      coin_reject  <= rej_n;
    end
  end

  always_comb begin
    state_n = state;
    item_n  = 1'b0;
    pulse_n = 1'b0;
    rej_n   = 1'b0;
    add_en  = 1'b0;
    sub_en  = 1'b0;
    dec_en  = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        if (state == COLLECT && (cancel || tmo)) begin
          state_n = CHANGE;
          pulse_n = 1'b1;
          rej_n   = coin_act;
        end else if (state == COLLECT && can_buy) begin
          state_n = VEND;
          sub_en  = 1'b1;
          item_n  = (sel == SEL_B);
          rej_n   = coin_act;
        end else if (coin_act) begin
          if (coin == COIN_BAD || ovf) begin
            rej_n = 1'b1;
          end else begin
            add_en  = 1'b1;
            state_n = COLLECT;
          end
        end
      end
      VEND: begin
        rej_n = coin_act;
        if (disp_ack) begin
          if (credit != '0) begin
            state_n = CHANGE;
            pulse_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          item_n = disp_item;
        end
      end
      CHANGE: begin
        rej_n  = coin_act;
        dec_en = 1'b1;
        if (credit == CW'(1)) begin
          state_n = IDLE;
        end else begin
          pulse_n = 1'b1;
        end
      end
    endcase
  end

  assign disp_req = (state == VEND);
  assign busy     = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed cases plus
// randomized traffic against a behavioural model.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin = 2'b00;
  logic [1:0] sel = 2'b00;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       disp_req, disp_item, change_pulse, coin_reject, busy;
  logic [3:0] credit;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 0;

  int m_credit = 0;
  bit m_vend = 0;
  bit m_pay = 0;
  bit m_item = 0;
  bit m_rej = 0;
  int m_idle = 0;

  localparam int TO = 10;

  always #5 clk = ~clk;

  vend_controller #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .coin        (coin),
    .sel         (sel),
    .cancel      (cancel),
    .disp_ack    (disp_ack),
    .disp_req    (disp_req),
    .disp_item   (disp_item),
    .change_pulse(change_pulse),
    .coin_reject (coin_reject),
    .credit      (credit),
    .busy        (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int c, s, price;
    bit tmo;
    c = int'(coin);
    s = int'(sel);
    tmo = 0;
    if (!rst) begin
      m_credit = 0; m_vend = 0; m_pay = 0;
      m_item = 0; m_rej = 0; m_idle = 0;
    end else if (m_vend) begin
      m_idle = 0;
      m_rej = (c != 0);
      if (disp_ack) begin
        m_vend = 0;
        m_item = 0;
        m_pay = (m_credit > 0);
      end
    end else if (m_pay) begin
      m_idle = 0;
      m_rej = (c != 0);
      m_credit = m_credit - 1;
      if (m_credit == 0) m_pay = 0;
    end else begin
      m_rej = 0;
      price = (s == 1) ? 3 : (s == 2) ? 4 : 0;
`ifdef VEND_TIMEOUT_EN
      if (m_credit > 0 && c == 0 && s == 0 && !cancel) begin
        m_idle++;
        if (m_idle == TO) begin
          tmo = 1;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
`endif
      if (m_credit > 0 && (cancel || tmo)) begin
        m_pay = 1;
        m_rej = (c != 0);
      end else if (m_credit > 0 && price != 0 && m_credit >= price) begin
        m_credit = m_credit - price;
        m_vend = 1;
        m_item = (s == 2);
        m_rej = (c != 0);
      end else if (c == 3) begin
        m_rej = 1;
      end else if (c != 0) begin
        if (m_credit + c > 8) m_rej = 1;
        else m_credit = m_credit + c;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_credit", int'(credit), m_credit);
      chk("m_disp_req", int'(disp_req), int'(m_vend));
      chk("m_disp_item", int'(disp_item), int'(m_item));
      chk("m_change_pulse", int'(change_pulse), int'(m_pay));
      chk("m_coin_reject", int'(coin_reject), int'(m_rej));
      chk("m_busy", int'(busy), int'(m_vend || m_pay));
    end
  end

  task automatic step(input logic [1:0] c = 2'b00,
                      input logic [1:0] s = 2'b00,
                      input logic cn = 1'b0,
                      input logic a = 1'b0);
    coin = c; sel = s; cancel = cn; disp_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int exp);
    int n, k;
    n = 0;
    k = 0;
    while (busy && k < 20) begin
      n += int'(change_pulse);
      step();
      k++;
    end
    chk({name, "_pulses"}, n, exp);
    chk({name, "_done"}, int'(busy), 0);
  endtask

  initial begin
    logic [1:0] rc, rs;
    rst = 1'b0;
    step(2'b10, 2'b01);
    cmp_on = 1;
    step(2'b10, 2'b01);
    chk("rst_credit", int'(credit), 0);
    chk("rst_req", int'(disp_req), 0);
    chk("rst_reject", int'(coin_reject), 0);
    chk("rst_pulse", int'(change_pulse), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;

    step(2'b01);
    step(2'b10);
    chk("exact_credit3", int'(credit), 3);
    step(2'b00, 2'b01);
    chk("exact_req", int'(disp_req), 1);
    chk("exact_item", int'(disp_item), 0);
    chk("exact_credit0", int'(credit), 0);
    step();
    step();
    chk("exact_req_held", int'(disp_req), 1);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    chk("exact_req_drop", int'(disp_req), 0);
    drain("exact", 0);

    step(2'b10);
    step(2'b10);
    step(2'b01);
    chk("chg_credit5", int'(credit), 5);
    step(2'b00, 2'b10);
    chk("chg_item", int'(disp_item), 1);
    chk("chg_credit1", int'(credit), 1);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    chk("chg_req_drop", int'(disp_req), 0);
    drain("chg", 1);

    repeat (4) step(2'b10);
    chk("ovf_credit8", int'(credit), 8);
    step(2'b01);
    chk("ovf_reject", int'(coin_reject), 1);
    chk("ovf_credit", int'(credit), 8);
    step();
    chk("ovf_reject_1cyc", int'(coin_reject), 0);
    step(2'b11);
    chk("bad_reject", int'(coin_reject), 1);
    step(2'b00, 2'b01);
    chk("ovf_vend_credit", int'(credit), 5);
    step(2'b01);
    chk("vend_coin_reject", int'(coin_reject), 1);
    chk("vend_coin_credit", int'(credit), 5);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    drain("ovf", 5);

    step(2'b10);
    step(2'b00, 2'b10);
    chk("short_sel_req", int'(disp_req), 0);
    chk("short_sel_credit", int'(credit), 2);
    step(2'b00, 2'b01, 1'b1);
    chk("cancel_req", int'(disp_req), 0);
    chk("cancel_pulse", int'(change_pulse), 1);
    drain("cancel", 2);

    step(2'b10);
    step(2'b01);
    step(2'b00, 2'b01);
    chk("mid_req", int'(disp_req), 1);
    rst = 1'b0;
    step();
    chk("mid_rst_req", int'(disp_req), 0);
    chk("mid_rst_credit", int'(credit), 0);
    rst = 1'b1;
    step();
    chk("mid_rst_pulse", int'(change_pulse), 0);

`ifdef VEND_TIMEOUT_EN
    step(2'b10);
    step(2'b01);
    repeat (TO - 1) step();
    chk("tmo_early", int'(change_pulse), 0);
    step();
    drain("tmo", 3);
`endif

    repeat (3000) begin
      int r;
      r = $urandom_range(0, 9);
      rc = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      rs = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rst = ($urandom_range(0, 299) != 0);
      step(rc, rs, $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
    end
    rst = 1'b1;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
